// File: rtl/tick_gen_pkg.sv
// Shared types and default widths for the tick generator.
// Holds the FSM state encoding used by tick_generator.
package tick_gen_pkg;

   localparam int DEF_COUNT_W = 8;
   localparam int DEF_SEL_W   = 5;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector with a load/suppress input.
// Ports: i_clk, i_rst (sync, high), i_sig sampled bit, i_load
// reloads history without detecting, i_en qualifies detection,
// o_edge combinational detect, o_rise registered pulse.
module edge_detect (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sig,
   input  logic i_load,
   input  logic i_en,
   output logic o_edge,
   output logic o_rise
);

   logic r_prev;
   logic r_rise;

   // History is always refreshed from the current sample, so a
   // load is simply a cycle in which detection is masked.
   assign o_edge = i_sig & ~r_prev & ~i_load & i_en;
   assign o_rise = r_rise;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_prev <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_prev <= i_sig;
         r_rise <= o_edge;
      end
   end

endmodule

// File: rtl/tick_generator.sv
// Tick generator: pulses on rising edges of a selected divided clock,
// counting ticks, optionally stopping after a burst of burst_len.
// Inputs: clock, reset (sync, high), divided_clocks, rate_sel, start,
// stop, burst_len. Outputs: tick, tick_count, busy, done.
module tick_generator
   import tick_gen_pkg::*;
#(
   parameter int COUNT_W = DEF_COUNT_W,
   parameter int SEL_W   = DEF_SEL_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [31:0]        divided_clocks,
   input  logic [SEL_W-1:0]   rate_sel,
   input  logic               start,
   input  logic               stop,
   input  logic [COUNT_W-1:0] burst_len,
   output logic               tick,
   output logic [COUNT_W-1:0] tick_count,
   output logic               busy,
   output logic               done
);

   state_t             r_state;
   logic [SEL_W-1:0]   r_sel;
   logic [COUNT_W-1:0] r_burst;
   logic [COUNT_W-1:0] r_count;
   logic               r_done;

   logic               w_bit;
   logic               w_load;
   logic               w_en;
   logic               w_edge;
   logic               w_rise;
   logic [COUNT_W-1:0] w_next_cnt;
   logic               w_last;

   assign w_bit      = divided_clocks[rate_sel];
   // A new select reloads history so the switch itself never ticks.
   assign w_load     = (rate_sel != r_sel);
   assign w_en       = (r_state == S_RUN) & ~stop;
   assign w_next_cnt = r_count + COUNT_W'(1);
   assign w_last     = (r_burst != '0) && (w_next_cnt == r_burst);

   edge_detect u_edge (
      .i_clk  (clock),
      .i_rst  (reset),
      .i_sig  (w_bit),
      .i_load (w_load),
      .i_en   (w_en),
      .o_edge (w_edge),
      .o_rise (w_rise)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_sel   <= '0;
         r_burst <= '0;
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         r_sel  <= rate_sel;
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start && !stop) begin
                  r_state <= S_RUN;
                  r_count <= '0;
                  r_burst <= burst_len;
               end
            end
            S_RUN: begin
               if (stop) begin
                  r_state <= S_IDLE;
               end else if (w_edge) begin
                  r_count <= w_next_cnt;
                  if (w_last) begin
                     r_state <= S_FINISH;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_FINISH: r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   assign tick       = w_rise;
   assign tick_count = r_count;
   assign busy       = (r_state == S_RUN);
   assign done       = r_done;

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator: vector table plus
// multi-cycle sequences for bursts, wrap, stop and reset.
module tb_tick_generator;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] dcl;
   logic [4:0]  rate_sel;
   logic        start;
   logic        stop;
   logic [7:0]  burst_len;
   logic        tick;
   logic [7:0]  tick_count;
   logic        busy;
   logic        done;

   logic [31:0] fc = '0;
   logic [31:0] tbl_dc;
   logic        use_tbl;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rst;
      logic        st;
      logic        sp;
      logic [4:0]  sel;
      logic [7:0]  bl;
      logic [31:0] dc;
      logic        t;
      logic [7:0]  c;
      logic        b;
      logic        d;
   } vec_t;

   vec_t vt [20];

   always #5 clk = ~clk;
   always @(posedge clk) fc <= fc + 32'd1;
   assign dcl = use_tbl ? tbl_dc : fc;

   tick_generator #(.COUNT_W(8), .SEL_W(5)) dut (
      .clock          (clk),
      .reset          (reset),
      .divided_clocks (dcl),
      .rate_sel       (rate_sel),
      .start          (start),
      .stop           (stop),
      .burst_len      (burst_len),
      .tick           (tick),
      .tick_count     (tick_count),
      .busy           (busy),
      .done           (done)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   int ticks, dn, last, gerr, busy_low, consec, wrap, found;
   logic [7:0] exp_cnt;
   logic [7:0] held;
   logic       prevt;

   initial begin
      //            rst st sp sel bl dc      t c  b d
      vt[0]  = '{1, 0, 0, 0, 0, 32'd0, 0, 0, 0, 0};
      vt[1]  = '{0, 1, 1, 0, 0, 32'd0, 0, 0, 0, 0};
      vt[2]  = '{0, 1, 0, 0, 2, 32'd1, 0, 0, 1, 0};
      vt[3]  = '{0, 0, 0, 0, 0, 32'd0, 0, 0, 1, 0};
      vt[4]  = '{0, 0, 0, 0, 0, 32'd1, 1, 1, 1, 0};
      vt[5]  = '{0, 1, 0, 0, 0, 32'd1, 0, 1, 1, 0};
      vt[6]  = '{0, 0, 0, 0, 0, 32'd0, 0, 1, 1, 0};
      vt[7]  = '{0, 0, 0, 0, 0, 32'd1, 1, 2, 0, 1};
      vt[8]  = '{0, 0, 0, 0, 0, 32'd1, 0, 2, 0, 0};
      vt[9]  = '{0, 1, 0, 0, 0, 32'd0, 0, 0, 1, 0};
      vt[10] = '{0, 0, 0, 0, 0, 32'd1, 1, 1, 1, 0};
      vt[11] = '{0, 0, 0, 0, 0, 32'd0, 0, 1, 1, 0};
      vt[12] = '{0, 0, 1, 0, 0, 32'd1, 0, 1, 0, 0};
      vt[13] = '{0, 0, 0, 0, 0, 32'd0, 0, 1, 0, 0};
      vt[14] = '{0, 1, 0, 0, 0, 32'd0, 0, 0, 1, 0};
      vt[15] = '{0, 0, 0, 3, 0, 32'd8, 0, 0, 1, 0};
      vt[16] = '{0, 0, 0, 3, 0, 32'd8, 0, 0, 1, 0};
      vt[17] = '{0, 0, 0, 3, 0, 32'd0, 0, 0, 1, 0};
      vt[18] = '{0, 0, 0, 3, 0, 32'd8, 1, 1, 1, 0};
      vt[19] = '{1, 0, 0, 3, 0, 32'd0, 0, 0, 0, 0};

      use_tbl   = 1'b1;
      tbl_dc    = '0;
      reset     = 1'b1;
      start     = 1'b0;
      stop      = 1'b0;
      rate_sel  = '0;
      burst_len = '0;
      #2;

      for (int i = 0; i < 20; i++) begin
         reset     = vt[i].rst;
         start     = vt[i].st;
         stop      = vt[i].sp;
         rate_sel  = vt[i].sel;
         burst_len = vt[i].bl;
         tbl_dc    = vt[i].dc;
         step();
         chk($sformatf("v%0d_tick", i), tick, vt[i].t);
         chk($sformatf("v%0d_count", i), tick_count, vt[i].c);
         chk($sformatf("v%0d_busy", i), busy, vt[i].b);
         chk($sformatf("v%0d_done", i), done, vt[i].d);
      end
      reset = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      use_tbl = 1'b0;

      // Burst of 3 on bit 2; burst_len change after start ignored
      do_reset();
      rate_sel  = 5'd2;
      burst_len = 8'd3;
      start     = 1'b1;
      step();
      start     = 1'b0;
      burst_len = 8'd7;
      ticks = 0; dn = 0; last = -1; gerr = 0;
      for (int i = 0; i < 80; i++) begin
         step();
         if (tick) begin
            if (last >= 0 && i - last != 8) gerr++;
            last = i;
            ticks++;
         end
         if (done) dn++;
      end
      chk("burst_ticks", ticks, 3);
      chk("burst_gap_err", gerr, 0);
      chk("burst_done", dn, 1);
      chk("burst_count", tick_count, 3);
      chk("burst_busy", busy, 0);

      // Continuous mode on bit 0 with wrap
      do_reset();
      rate_sel  = 5'd0;
      burst_len = 8'd0;
      start     = 1'b1;
      step();
      start = 1'b0;
      exp_cnt = '0; prevt = 1'b0; last = -1;
      busy_low = 0; consec = 0; wrap = 0; gerr = 0;
      for (int i = 0; i < 600; i++) begin
         step();
         if (!busy) busy_low++;
         if (tick) begin
            exp_cnt = exp_cnt + 8'd1;
            chk("cont_count", tick_count, exp_cnt);
            if (prevt) consec++;
            if (last >= 0 && i - last != 2) gerr++;
            if (tick_count == 8'd0) wrap = 1;
            last = i;
         end
         prevt = tick;
      end
      chk("cont_wrap", wrap, 1);
      chk("cont_busy_low", busy_low, 0);
      chk("cont_consec", consec, 0);
      chk("cont_gap_err", gerr, 0);

      // Stop between ticks
      found = 0;
      for (int i = 0; i < 10 && found == 0; i++) begin
         step();
         if (tick) found = 1;
      end
      chk("stop_wait_tick", found, 1);
      held = tick_count;
      stop = 1'b1;
      step();
      chk("stop_busy", busy, 0);
      chk("stop_done", done, 0);
      chk("stop_tick", tick, 0);
      chk("stop_count", tick_count, held);
      stop = 1'b0;
      step();
      step();
      chk("stop_count_later", tick_count, held);
      start = 1'b1;
      stop  = 1'b1;
      step();
      chk("startstop_busy", busy, 0);
      start = 1'b0;
      stop  = 1'b0;

      // Reset mid-burst, then full restart
      do_reset();
      rate_sel  = 5'd1;
      burst_len = 8'd4;
      start     = 1'b1;
      step();
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         step();
         if (tick) found = 1;
      end
      chk("rst_wait_tick", found, 1);
      chk("rst_first_count", tick_count, 1);
      step();
      reset = 1'b1;
      start = 1'b1;
      step();
      reset = 1'b0;
      start = 1'b0;
      chk("rst_tick", tick, 0);
      chk("rst_count", tick_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      dn = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (done) dn++;
      end
      chk("rst_no_done", dn, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      ticks = 0; dn = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (tick) ticks++;
         if (done) dn++;
      end
      chk("restart_ticks", ticks, 4);
      chk("restart_done", dn, 1);
      chk("restart_count", tick_count, 4);
      chk("restart_busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
